// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-address sequencer and the
// branch-target arithmetic it shares with later BTB work.
package pc_seq_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_e;

    localparam int unsigned PC_STEP          = 4;
    localparam int unsigned OFFSET_SHIFT     = 2;
    localparam int unsigned FLUSH_CNT_W      = 3;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-resolution bus from EX/MEM into the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 64
) ();

    logic              br_valid;
    logic              br_taken;
    logic              br_uncond;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_offset;

    modport master (
        output br_valid,
        output br_taken,
        output br_uncond,
        output br_pc,
        output br_offset
    );

    modport slave (
        input br_valid,
        input br_taken,
        input br_uncond,
        input br_pc,
        input br_offset
    );

endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// Branch-target adder: word-aligned branch PC plus the word offset scaled to bytes.
// Purely combinational; the sum wraps modulo 2^ADDR_W.
module branch_target_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] aligned_pc;
    logic [ADDR_W-1:0] scaled_offset;

    assign aligned_pc    = {br_pc[ADDR_W-1:OFFSET_SHIFT], {OFFSET_SHIFT{1'b0}}};
    // Offset bits shifted past the top are dropped, matching the datapath adder.
    assign scaled_offset = br_offset << OFFSET_SHIFT;
    assign target        = aligned_pc + scaled_offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the pipelined LEGv8 core: sequential step, hazard
// hold, branch redirect with a fixed wrong-path flush window and a redirect counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          ADDR_W       = 64,
    parameter logic [63:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    pc_sequencer_if.slave     br,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect,
    output logic [CNT_W-1:0]  redirect_count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0]      STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0]      PC_INIT    = RESET_PC[ADDR_W-1:0];

    seq_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [ADDR_W-1:0]      restart_pc_q, restart_pc_d;
    logic                   pc_valid_q, pc_valid_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]      target;
    logic                   take;

    branch_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .br_pc     (br.br_pc),
        .br_offset (br.br_offset),
        .target    (target)
    );

    // Resolutions seen during FLUSH come from wrong-path instructions.
    assign take = ~reset & br.br_valid & (br.br_taken | br.br_uncond) & (state_q == RUN);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pc_d         = pc_q;
        restart_pc_d = restart_pc_q;
        pc_valid_d   = pc_valid_q;
        count_d      = count_q;

        unique case (state_q)
            RUN: begin
                if (take) begin
                    pc_d         = target;
                    restart_pc_d = target;
                    flush_cnt_d  = FLUSH_LOAD;
                    state_d      = FLUSH;
                    pc_valid_d   = 1'b0;
                    if (count_q != '1) count_d = count_q + 1'b1;
                end else if (!stall) begin
                    pc_d       = pc_q + STEP;
                    pc_valid_d = 1'b1;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
                    // Re-present the target so it is the first fetch once valid rises.
                    state_d    = RUN;
                    pc_valid_d = 1'b1;
                    pc_d       = restart_pc_q;
                end else if (!stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= RUN;
            flush_cnt_q  <= '0;
            pc_q         <= PC_INIT;
            restart_pc_q <= PC_INIT;
            pc_valid_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            pc_q         <= pc_d;
            restart_pc_q <= restart_pc_d;
            pc_valid_q   <= pc_valid_d;
            count_q      <= count_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid       = pc_valid_q;
    assign flush_if_id    = (state_q == FLUSH);
    assign flush_id_ex    = (state_q == FLUSH);
    assign redirect       = take;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: cycle model feeds a scoreboard queue,
// scenario tasks add targeted checks against hand-computed addresses.
module tb_pc_sequencer;

    localparam int ADDR_W       = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 2;

    typedef struct {
        logic [63:0] pc;
        logic        valid;
        logic        flush;
        int          count;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              stall;
    logic [ADDR_W-1:0] pc_out;
    logic              pc_valid;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              redirect;
    logic [CNT_W-1:0]  redirect_count;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    pc_sequencer #(
        .ADDR_W       (ADDR_W),
        .RESET_PC     (64'h0),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .br             (bus.slave),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .redirect       (redirect),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Reference model state
    logic [63:0] m_pc    = 64'h0;
    logic [63:0] m_saved = 64'h0;
    logic        m_valid = 1'b0;
    logic        m_flush = 1'b0;
    int          m_left  = 0;
    int          m_count = 0;

    // One clock cycle: drive inputs, check the combinational pulse, predict, check after edge.
    task automatic tick(input logic rst, input logic stl, input logic bv, input logic bt,
                        input logic bu, input logic [63:0] bpc, input logic [63:0] boff);
        exp_t        e;
        logic        exp_redirect;
        logic [63:0] tgt;
        reset          = rst;
        stall          = stl;
        bus.br_valid   = bv;
        bus.br_taken   = bt;
        bus.br_uncond  = bu;
        bus.br_pc      = bpc;
        bus.br_offset  = boff;
        #2;
        exp_redirect = !rst && bv && (bt || bu) && !m_flush;
        n_checks++;
        if (redirect !== exp_redirect) begin
            n_errors++;
            $display("FAIL redirect: got %b want %b at %0t", redirect, exp_redirect, $time);
        end
        tgt = (bpc & ~64'h3) + (boff * 64'd4);
        if (rst) begin
            m_pc = 64'h0; m_saved = 64'h0; m_valid = 1'b0; m_flush = 1'b0;
            m_left = 0; m_count = 0;
        end else if (exp_redirect) begin
            m_pc = tgt; m_saved = tgt; m_valid = 1'b0; m_flush = 1'b1;
            m_left = FLUSH_CYCLES;
            m_count = (m_count == 3) ? 3 : m_count + 1;
        end else if (m_flush) begin
            if (m_left == 1) begin
                m_flush = 1'b0; m_valid = 1'b1; m_pc = m_saved; m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (!stl) m_pc = m_pc + 64'd4;
            end
        end else if (!stl) begin
            m_pc = m_pc + 64'd4; m_valid = 1'b1;
        end
        e.pc = m_pc; e.valid = m_valid; e.flush = m_flush; e.count = m_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (pc_out !== e.pc) begin
            n_errors++;
            $display("FAIL pc_out: got %h want %h at %0t", pc_out, e.pc, $time);
        end
        n_checks++;
        if (pc_valid !== e.valid) begin
            n_errors++;
            $display("FAIL pc_valid: got %b want %b at %0t", pc_valid, e.valid, $time);
        end
        n_checks++;
        if (flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
            n_errors++;
            $display("FAIL flush: got if_id=%b id_ex=%b want %b at %0t",
                     flush_if_id, flush_id_ex, e.flush, $time);
        end
        n_checks++;
        if (redirect_count !== CNT_W'(e.count)) begin
            n_errors++;
            $display("FAIL redirect_count: got %0d want %0d at %0t", redirect_count, e.count, $time);
        end
        n_checks++;
        if (pc_out[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL pc_align: got %b want 00 at %0t", pc_out[1:0], $time);
        end
    endtask

    task automatic nop();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h80, 64'h7);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h40, 64'h3);
        n_checks++;
        if (pc_out !== 64'h0 || pc_valid !== 1'b0 || flush_if_id !== 1'b0 || redirect_count !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%h valid=%b flush=%b cnt=%0d want 0/0/0/0",
                     pc_out, pc_valid, flush_if_id, redirect_count);
        end
        for (int i = 1; i <= 4; i++) begin
            nop();
            n_checks++;
            if (pc_out !== 64'(4 * i) || pc_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL free_run: got pc=%h valid=%b want pc=%h valid=1", pc_out, pc_valid, 4 * i);
            end
        end
    endtask

    task automatic test_redirect();
        repeat (4) nop();
        n_checks++;
        if (pc_out !== 64'h20) begin
            n_errors++;
            $display("FAIL pre_redirect_pc: got %h want 20", pc_out);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h18, 64'd5);
        n_checks++;
        if (pc_out !== 64'h2C || flush_if_id !== 1'b1 || pc_valid !== 1'b0 || redirect_count !== 2'd1) begin
            n_errors++;
            $display("FAIL uncond_target: got pc=%h flush=%b valid=%b cnt=%0d want 2c/1/0/1",
                     pc_out, flush_if_id, pc_valid, redirect_count);
        end
        nop();
        nop();
        n_checks++;
        if (pc_out !== 64'h2C || pc_valid !== 1'b1 || flush_id_ex !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_exit: got pc=%h valid=%b flush=%b want 2c/1/0", pc_out, pc_valid, flush_id_ex);
        end
    endtask

    task automatic test_not_taken();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h40, -64'd3);
        n_checks++;
        if (pc_out !== 64'h30) begin
            n_errors++;
            $display("FAIL not_taken_seq: got %h want 30", pc_out);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h40, -64'd3);
        n_checks++;
        if (pc_out !== 64'h34 || redirect_count !== 2'd2) begin
            n_errors++;
            $display("FAIL cond_taken_target: got pc=%h cnt=%0d want 34/2", pc_out, redirect_count);
        end
    endtask

    task automatic test_flush_ignore_and_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 64'd100);
        n_checks++;
        if (pc_out !== 64'h38 || redirect_count !== 2'd2 || flush_if_id !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_ignore: got pc=%h cnt=%0d flush=%b want 38/2/1", pc_out, redirect_count, flush_if_id);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_checks++;
        if (pc_out !== 64'h0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || redirect_count !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid_flush: got pc=%h flush=%b/%b cnt=%0d want 0/0/0/0",
                     pc_out, flush_if_id, flush_id_ex, redirect_count);
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        while (pc_out !== 64'h100 && guard < 100) begin
            nop();
            guard++;
        end
        n_checks++;
        if (pc_out !== 64'h100) begin
            n_errors++;
            $display("FAIL reach_0x100: got %h want 100 within 100 cycles", pc_out);
        end
        repeat (3) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
            n_checks++;
            if (pc_out !== 64'h100) begin
                n_errors++;
                $display("FAIL stall_hold: got %h want 100", pc_out);
            end
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h100, 64'd2);
        n_checks++;
        if (pc_out !== 64'h108 || flush_if_id !== 1'b1 || redirect_count !== 2'd1) begin
            n_errors++;
            $display("FAIL stall_and_take: got pc=%h flush=%b cnt=%0d want 108/1/1", pc_out, flush_if_id, redirect_count);
        end
        nop();
        nop();
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        nop();
        nop();
        n_checks++;
        if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || pc_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL top_of_space: got pc=%h valid=%b want fffffffffffffffc/1", pc_out, pc_valid);
        end
        nop();
        n_checks++;
        if (pc_out !== 64'h0) begin
            n_errors++;
            $display("FAIL pc_wrap: got %h want 0", pc_out);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8, -64'd4);
        n_checks++;
        if (pc_out !== 64'hFFFF_FFFF_FFFF_FFF8 || redirect_count !== 2'd3) begin
            n_errors++;
            $display("FAIL target_wrap: got pc=%h cnt=%0d want fffffffffffffff8/3", pc_out, redirect_count);
        end
        nop();
        nop();
    endtask

    task automatic test_saturate();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h3, 64'h4000_0000_0000_0001);
        n_checks++;
        if (pc_out !== 64'h4 || redirect_count !== 2'd3) begin
            n_errors++;
            $display("FAIL saturate: got pc=%h cnt=%0d want 4/3", pc_out, redirect_count);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_checks++;
        if (pc_out !== 64'h4 || pc_valid !== 1'b1 || flush_if_id !== 1'b0) begin
            n_errors++;
            $display("FAIL stalled_flush_exit: got pc=%h valid=%b flush=%b want 4/1/0", pc_out, pc_valid, flush_if_id);
        end
        nop();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h200, 64'd1);
        n_checks++;
        if (pc_out !== 64'h204 || redirect_count !== 2'd3) begin
            n_errors++;
            $display("FAIL saturate_hold: got pc=%h cnt=%0d want 204/3", pc_out, redirect_count);
        end
        nop();
        nop();
        nop();
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_uncond = 1'b0;
        bus.br_pc     = '0;
        bus.br_offset = '0;
        test_reset();
        test_redirect();
        test_not_taken();
        test_flush_ignore_and_reset();
        test_stall();
        test_wrap();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
